rf_dump_reader: RTL and testbench

RF_DUMP_READER -- requirements
Module: rf_dump_reader

---
 rtl/rf_dump_reader.sv | 170 +++++++++++++++++
 tb/tb_rf_dump_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: streams a contiguous window of a register file out over a
// valid/ready port, one word per cycle, and keeps a running XOR signature of
// the words the consumer accepted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; output port empty
// RUN   | reading words; a new beat is captured whenever the port slot frees
// DRAIN | final beat captured; waiting for it to be accepted
module rf_dump_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] sig_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] sig_q, sig_d;

  logic                  hs;
  logic                  capture;

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
    end
  end

  // Next-state, capture and handshake logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    hs      = valid_q && out_ready_i;
    capture = (state_q == S_RUN) && (!valid_q || out_ready_i);

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          if (len_i == '0) begin
            // Empty dump: report completion without ever leaving IDLE.
            done_d = 1'b1;
          end else begin
            idx_d   = base_i;
            rem_d   = len_i;
            sig_d   = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort_i) begin
          // The beat sitting on the port is dropped, even if accepted now.
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (hs) begin
            sig_d = sig_q ^ data_q;
          end
          if (capture) begin
            addr_d  = idx_q;
            data_d  = rdata_i;
            valid_d = 1'b1;
            last_d  = (rem_q == REM_ONE);
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == REM_ONE) begin
              state_d = S_DRAIN;
            end
          end else if (hs) begin
            valid_d = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else if (hs) begin
          sig_d   = sig_q ^ data_q;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    // Registered from the next state so busy drops on the cycle done rises.
    busy_d = (state_d != S_IDLE);
  end

  assign raddr_o     = idx_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sig_o       = sig_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: directed scenarios with literal expectations plus
// randomized dumps checked every cycle against a transaction-level model.
module tb_rf_dump_reader;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int NREG = 64;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i, out_ready_i;
  logic [AW-1:0] base_i, raddr_o, out_addr_o;
  logic [AW:0]   len_i;
  logic [DW-1:0] rdata_i, out_data_o, sig_o;
  logic          out_valid_o, out_last_o, busy_o, done_o;

  logic [DW-1:0] mem [NREG];
  assign rdata_i = mem[raddr_o];

  rf_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .len_i(len_i), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o), .sig_o(sig_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t         q[$];
  bit            en = 0;
  bit            m_active = 0;
  bit            exp_done = 0;
  bit            after_rst = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] m_sig = '0;
  int            acc_cnt = 0;
  int            done_cnt = 0;

  // Per-cycle compare of DUT outputs against the model, then model update.
  always @(negedge clk) begin
    if (en) begin
      bit was_active;
      was_active = m_active;
      if (done_o === 1'b1) done_cnt++;
      if (after_rst) begin
        chk("rst valid", out_valid_o, 0);
        chk("rst addr", out_addr_o, 0);
        chk("rst data", out_data_o, 0);
        chk("rst last", out_last_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst sig", sig_o, 0);
        chk("rst raddr", raddr_o, 0);
        after_rst = 0;
      end else begin
        chk("busy", busy_o, was_active);
        chk("done", done_o, exp_done);
        chk("sig", sig_o, m_sig);
        if (prev_stall) chk("stall hold valid", out_valid_o, 1);
        if (out_valid_o === 1'b1) begin
          if (q.size() == 0) chk("spurious beat", 1, 0);
          else begin
            chk("beat addr", out_addr_o, q[0].addr);
            chk("beat data", out_data_o, q[0].data);
            chk("beat last", out_last_o, q[0].last);
          end
        end
      end
      exp_done = 0;
      if (rst) begin
        q.delete(); m_active = 0; m_sig = '0; after_rst = 1; prev_stall = 0;
      end else if (was_active && abort_i) begin
        q.delete(); m_active = 0; prev_stall = 0;
      end else begin
        if (was_active && out_valid_o && out_ready_i && q.size() > 0) begin
          m_sig ^= q[0].data;
          void'(q.pop_front());
          acc_cnt++;
          if (q.size() == 0) begin
            m_active = 0;
            exp_done = 1;
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        if (!was_active && start_i && !abort_i) begin
          if (len_i == 0) exp_done = 1;
          else begin
            for (int i = 0; i < int'(len_i); i++) begin
              beat_t bt;
              bt.addr = base_i + AW'(i);
              bt.data = mem[bt.addr];
              bt.last = (i == int'(len_i) - 1);
              q.push_back(bt);
            end
            m_sig = '0;
            m_active = 1;
          end
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  int ready_mode = 0;  // 0 always, 1 toggle, 2 never, 3 random

  // Downstream ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      2:       out_ready_i = 1'b0;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || busy_o) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({name, " timeout"}, 1, 0);
    tick();
  endtask

  task automatic pattern_mem();
    for (int i = 0; i < NREG; i++) mem[i] = DW'(i) * 32'h01010101;
  endtask

  initial begin
    int a0, d0;
    rst = 1; start_i = 0; abort_i = 0; base_i = '0; len_i = '0; out_ready_i = 1;
    pattern_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", out_valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset sig", sig_o, 0);
    chk("reset raddr", raddr_o, 0);
    en = 1;
    tick();
    rst = 0;
    tick();

    // Basic dump: beats on cycles 2..5, done on 6.
    tick(); start_i = 1; base_i = 0; len_i = 4;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t1 valid", out_valid_o, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk("t1 addr", out_addr_o, c - 2);
        chk("t1 data", out_data_o, (c - 2) * 32'h01010101);
        chk("t1 last", out_last_o, (c == 5));
      end
      chk("t1 done", done_o, (c == 6));
      chk("t1 busy", busy_o, (c >= 1 && c <= 5));
      tick(); start_i = 0;
    end
    chk("t1 sig", sig_o, 32'h0);

    // Wrap-around 62, 63, 0, 1.
    tick(); start_i = 1; base_i = 62; len_i = 4;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t2 valid", out_valid_o, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        a0 = (62 + c - 2) % 64;
        chk("t2 addr", out_addr_o, a0);
        chk("t2 last", out_last_o, (c == 5));
      end
      tick(); start_i = 0;
    end

    // Toggling ready: exactly 3 accepted beats 5,6,7 and one done.
    wait_idle("t3 pre");
    ready_mode = 1;
    acc_cnt = 0; done_cnt = 0;
    tick(); start_i = 1; base_i = 5; len_i = 3;
    tick(); start_i = 0;
    wait_idle("t3");
    tick();
    chk("t3 accepted", acc_cnt, 3);
    chk("t3 dones", done_cnt, 1);
    chk("t3 sig", sig_o, 32'h05050505 ^ 32'h06060606 ^ 32'h07070707);
    ready_mode = 0;

    // Zero length: done one cycle later, nothing else.
    tick(); tick();
    tick(); start_i = 1; base_i = 9; len_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4 valid", out_valid_o, 0);
      chk("t4 busy", busy_o, 0);
      chk("t4 done", done_o, (c == 1));
      tick(); start_i = 0;
    end

    // Abort after two accepted beats of a len=10 dump.
    done_cnt = 0;
    tick(); start_i = 1; base_i = 0; len_i = 10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tick(); start_i = 0;
    end
    abort_i = 1;
    @(negedge clk);
    tick(); abort_i = 0;
    @(negedge clk);
    chk("t5 valid", out_valid_o, 0);
    chk("t5 busy", busy_o, 0);
    chk("t5 sig", sig_o, 32'h01010101);
    tick(); tick();
    chk("t5 dones", done_cnt, 0);
    acc_cnt = 0;
    tick(); start_i = 1; base_i = 10; len_i = 2;
    tick(); start_i = 0;
    wait_idle("t5 restart");
    chk("t5 restart beats", acc_cnt, 2);

    // Reset while in DRAIN with ready low.
    ready_mode = 2;
    done_cnt = 0;
    tick(); tick();
    tick(); start_i = 1; base_i = 20; len_i = 1;
    @(negedge clk);
    tick(); start_i = 0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6 drain valid", out_valid_o, 1);
    chk("t6 drain last", out_last_o, 1);
    tick(); rst = 1;
    @(negedge clk);
    tick(); rst = 0;
    @(negedge clk);
    chk("t6 valid", out_valid_o, 0);
    chk("t6 last", out_last_o, 0);
    chk("t6 data", out_data_o, 0);
    chk("t6 busy", busy_o, 0);
    chk("t6 done", done_o, 0);
    tick(); tick();
    chk("t6 dones", done_cnt, 0);
    ready_mode = 0;

    // Randomized dumps with stalls, aborts and stray starts.
    for (int it = 0; it < 60; it++) begin
      int r, ab_at, cyc;
      if ($urandom_range(0, 3) == 0) for (int i = 0; i < NREG; i++) mem[i] = $urandom;
      r = $urandom_range(0, 2);
      ready_mode = (r == 2) ? 3 : r;
      r = $urandom_range(0, 7);
      start_i = 1;
      base_i  = AW'($urandom);
      len_i   = (r == 0) ? 0 : (r == 1) ? 64 : (AW+1)'($urandom_range(1, 20));
      abort_i = ($urandom_range(0, 15) == 0);
      tick();
      start_i = 0; abort_i = 0;
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      cyc = 0;
      while ((m_active || busy_o) && cyc < 3000) begin
        abort_i = (cyc == ab_at);
        if ($urandom_range(0, 9) == 0) begin
          start_i = 1; base_i = AW'($urandom); len_i = (AW+1)'($urandom_range(1, 64));
        end else start_i = 0;
        tick();
        cyc++;
      end
      start_i = 0; abort_i = 0;
      if (cyc >= 3000) chk("random timeout", 1, 0);
      tick(); tick();
    end

    en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
